fetch_unit: RTL and testbench

- Instruction fetch stage sitting upstream of the control unit.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents the instruction, plus the op/funct3/funct7_5 slices, to decode.
- Consumes PCSrc/pc_target from the execute stage, redirects the PC, and discards stale fetches.

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads and buffers returned instructions for decode.
// Latency: a response is visible to decode the cycle after it arrives. Optional FETCH_STATS_EN adds counters.
// Backpressure: requests stop once outstanding plus buffered entries reach FIFO_DEPTH.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Caller guarantees no write when full and no read when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_rdy) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_vld) - CW'(rd_rdy);
    end
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic                  funct7_5
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_dropped
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  state_t                state, state_n;
  logic [CW-1:0]         outstanding, drop_cnt, drop_n, fifo_count;
  logic [CW:0]           credit_used;
  logic [ADDR_WIDTH-1:0] fetch_pc, rsp_pc, target_aligned;
  logic                  active, redirect, req_fire, rsp_seen, rsp_drop, push, pop;
  entry_t                push_entry, head;

  assign active         = (state != BOOT);
  assign redirect       = PCSrc && active;
  assign target_aligned = pc_target & ~ADDR_WIDTH'(3);
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};

  assign imem_req_valid = active && !PCSrc && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is stray (e.g. issued before a reset) and is ignored.
  assign rsp_seen = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_seen && (drop_cnt != '0);
  assign push     = rsp_seen && (drop_cnt == '0) && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;

  assign push_entry.dat = imem_rsp_data;
  assign push_entry.pc  = rsp_pc;

  fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect),
    .wr_vld (push),
    .wr_dat (push_entry),
    .rd_rdy (pop),
    .rd_dat (head),
    .count  (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? head.dat : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7_5    = instr[30];

  always_comb begin
    state_n = state;
    drop_n  = drop_cnt;
    // Everything still in flight at a redirect is stale, except a response landing this very cycle.
    if (redirect)      drop_n = outstanding - CW'(rsp_seen);
    else if (rsp_drop) drop_n = drop_cnt - CW'(1);
    case (state)
      BOOT:       state_n = RUN;
      RUN, DRAIN: state_n = (drop_n != '0) ? DRAIN : RUN;
      default:    state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      drop_cnt    <= '0;
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
    end else begin
      state       <= state_n;
      drop_cnt    <= drop_n;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_seen);
      if (redirect) begin
        fetch_pc <= target_aligned;
        rsp_pc   <= target_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (push)     rsp_pc   <= rsp_pc + ADDR_WIDTH'(4);
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] drop_inc;
  logic [32:0] drop_sum;

  // Dropped covers discarded responses plus buffered entries thrown away by a flush.
  assign drop_inc = 32'(rsp_seen && !push) + (redirect ? 32'(fifo_count) : 32'd0);
  assign drop_sum = {1'b0, stat_dropped} + {1'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      if (push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
      stat_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with random latency, queue-based
// reference of the expected instruction stream and request address sequence.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrc;
  logic [31:0] pc_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSrc          (PCSrc),
    .pc_target      (pc_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .funct7_5       (funct7_5)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          npop = 0;
  int          p_rdy, p_ir, p_redir, lat_max, guard;
  logic [31:0] exp_pc, req_exp, prev_addr;
  logic        prev_hold, post_reset, rsp_from_mq;

  // Memory contents: address 0 holds add x2,x1,x2 (0x00208133).
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0020_8133;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    PCSrc          = 1'b0;
    pc_target      = '0;
    instr_ready    = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_slices", {20'd0, op, funct3, funct7_5, 1'b0}, 0);
    mq.delete();
    exp_pc    = RESET_PC;
    req_exp   = RESET_PC;
    prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_idle", 32'(imem_req_valid), 0);
    // Stray response during the boot cycle must be ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    post_reset     = 1'b1;
    guard          = 1;
  endtask

  task automatic step();
    logic [31:0] w;
    @(posedge clk);
    cyc++;
    #1;
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    instr_ready    = ($urandom_range(0, 99) < p_ir);
    PCSrc          = (guard == 0) && ($urandom_range(0, 99) < p_redir);
    if (guard > 0) guard--;
    if ($urandom_range(0, 9) == 0) pc_target = 32'hFFFF_FFF0 | $urandom_range(0, 3);
    else                           pc_target = $urandom_range(0, 4095);
    rsp_from_mq = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp_from_mq;
    imem_rsp_data  = rsp_from_mq ? memfn(mq[0].addr) : $urandom;
    @(negedge clk);

    if (post_reset) begin
      chk("first_req", 32'(imem_req_valid), 1);
      post_reset = 1'b0;
    end
    chk("credit", (mq.size() <= DEPTH) ? 32'd1 : 32'd0, 1);
    if (PCSrc) chk("redir_noreq", 32'(imem_req_valid), 0);
    if (prev_hold && !PCSrc) begin
      chk("hold_valid", 32'(imem_req_valid), 1);
      chk("hold_addr", imem_req_addr, prev_addr);
    end
    prev_hold = imem_req_valid && !imem_req_ready;
    prev_addr = imem_req_addr;

    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, req_exp);
      mq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(1, lat_max)});
      req_exp += 32'd4;
    end
    if (rsp_from_mq) void'(mq.pop_front());

    if (instr_valid && instr_ready && !PCSrc) begin
      w = memfn(exp_pc);
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, w);
      chk("op", 32'(op), 32'(w[6:0]));
      chk("funct3", 32'(funct3), 32'(w[14:12]));
      chk("funct7_5", 32'(funct7_5), 32'(w[30]));
      exp_pc += 32'd4;
      npop++;
    end
    if (PCSrc) begin
      exp_pc  = pc_target & ~32'd3;
      req_exp = pc_target & ~32'd3;
    end
  endtask

  task automatic run(input int n, input int rdy, input int lat, input int ir, input int redir);
    p_rdy   = rdy;
    lat_max = lat;
    p_ir    = ir;
    p_redir = redir;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    post_reset = 1'b0;
    guard      = 0;
    do_reset();
    // Streaming with a one-cycle memory.
    run(20, 100, 1, 100, 0);
    // Decode stalled: buffer fills and requests stop.
    run(10, 100, 1, 0, 0);
    chk("full_stall_req", 32'(imem_req_valid), 0);
    chk("full_stall_instr", 32'(instr_valid), 1);
    run(10, 100, 1, 100, 0);
    // Random traffic with redirects.
    run(400, 70, 3, 70, 8);
    // Memory stall, then reset asserted mid-cycle.
    run(5, 0, 3, 100, 0);
    chk("stall_valid", 32'(imem_req_valid), 1);
    do_reset();
    run(20, 100, 1, 100, 0);
    run(400, 60, 4, 60, 15);
    chk("progress", (npop > 100) ? 32'd1 : 32'd0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
